// File: rtl/sram22_arb_pkg.sv
// Shared types for the sram22 two-requester arbiter: FSM states, requester index, response FIFO depth.
// The read-room helper keeps the eligibility rule in one place.
package sram22_arb_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef logic req_idx_t;
  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

  localparam int FIFO_DEPTH = 2;

  // A new read fits only if queued + outstanding data, less this cycle's pop, leaves a free slot.
  function automatic logic rd_room(input logic [1:0] cnt, input logic infl, input logic pop);
    logic [2:0] occ;
    occ = {1'b0, cnt} + {2'b00, infl} - {2'b00, pop};
    return occ < 3'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/sram22_arbiter_if.sv
// One requester channel of the sram22 arbiter: request handshake plus read-response handshake.
// master = core-side agent, slave = arbiter.
interface sram22_arbiter_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [WMASK_WIDTH-1:0] req_wmask;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_WIDTH-1:0]  rsp_rdata;

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram22_rsp_fifo.sv
// Two-entry valid/ready response FIFO with occupancy output; data is visible the cycle after push.
// Push carries no ready: the arbiter's eligibility rule guarantees a free slot.
module sram22_rsp_fifo
  import sram22_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_dat_i,
  output logic                  out_vld_o,
  input  logic                  out_rdy_i,
  output logic [DATA_WIDTH-1:0] out_dat_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;
  logic                  pop;

  assign out_vld_o = (count_q != 2'd0);
  assign out_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign pop       = out_vld_o & out_rdy_i;
  assign count_d   = count_q + 2'(push_i) - 2'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/sram22_arbiter.sv
// Round-robin sharing of one single-port sram22 macro between two requesters, with per-requester read FIFOs.
// Optional macro SRAM22_ARB_INIT_EN zero-fills the macro after reset before any request is accepted.
module sram22_arbiter
  import sram22_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram22_arbiter_if.slave        req0,
  sram22_arbiter_if.slave        req1,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout,
  output logic                   init_done
);

  logic [1:0] cnt0, cnt1;
  logic       pop0, pop1;
  logic       elig0, elig1, g0, g1;
  logic       accept_en;
  logic [1:0] inflight_q, inflight_d;
  req_idx_t   rr_q, rr_d;

`ifdef SRAM22_ARB_INIT_EN
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  init_done_q;
  logic                  init_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
          if (init_cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign accept_en = rst_n & (state_q == ST_RUN);
  assign init_wr   = rst_n & (state_q == ST_INIT);
  assign init_done = init_done_q;
`else
  assign accept_en = rst_n;
  assign init_done = 1'b1;
`endif

  assign pop0  = req0.rsp_valid & req0.rsp_ready;
  assign pop1  = req1.rsp_valid & req1.rsp_ready;
  assign elig0 = accept_en & req0.req_valid & (req0.req_we | rd_room(cnt0, inflight_q[0], pop0));
  assign elig1 = accept_en & req1.req_valid & (req1.req_we | rd_room(cnt1, inflight_q[1], pop1));

  // Pointer only matters on contention, so it only advances on contended grants.
  assign g0   = elig0 & (~elig1 | (rr_q == REQ0));
  assign g1   = elig1 & (~elig0 | (rr_q == REQ1));
  assign rr_d = (elig0 & elig1) ? ~rr_q : rr_q;

  assign req0.req_ready = g0;
  assign req1.req_ready = g1;
  assign inflight_d     = {g1 & ~req1.req_we, g0 & ~req0.req_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= REQ0;
      inflight_q <= 2'b00;
    end else begin
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (g0) begin
      sram_we    = req0.req_we;
      sram_wmask = req0.req_we ? req0.req_wmask : '0;
      sram_addr  = req0.req_addr;
      sram_din   = req0.req_wdata;
    end else if (g1) begin
      sram_we    = req1.req_we;
      sram_wmask = req1.req_we ? req1.req_wmask : '0;
      sram_addr  = req1.req_addr;
      sram_din   = req1.req_wdata;
    end
`ifdef SRAM22_ARB_INIT_EN
    if (init_wr) begin
      sram_we    = 1'b1;
      sram_wmask = '1;
      sram_addr  = init_cnt_q;
      sram_din   = '0;
    end
`endif
  end

  // Macro read data lands one edge after the accept, so the inflight flag doubles as the push strobe.
  sram22_rsp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q[0]),
    .push_dat_i (sram_dout),
    .out_vld_o  (req0.rsp_valid),
    .out_rdy_i  (req0.rsp_ready),
    .out_dat_o  (req0.rsp_rdata),
    .count_o    (cnt0)
  );

  sram22_rsp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q[1]),
    .push_dat_i (sram_dout),
    .out_vld_o  (req1.rsp_valid),
    .out_rdy_i  (req1.rsp_ready),
    .out_dat_o  (req1.rsp_rdata),
    .count_o    (cnt1)
  );

endmodule

// File: tb/tb_sram22_arbiter.sv
// Directed bench for sram22_arbiter with a behavioural single-port macro (1-cycle read, X after write).
// Build with SRAM22_ARB_INIT_EN defined to exercise the zero-fill sweep.
module tb_sram22_arbiter;

  localparam logic [63:0] A0 = 64'h0A0A_0000_0000_0010;
  localparam logic [63:0] A1 = 64'h0A0A_0000_0000_0011;
  localparam logic [63:0] B0 = 64'h0B0B_0000_0000_0020;
  localparam logic [63:0] B1 = 64'h0B0B_0000_0000_0021;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sram_we;
  logic [7:0]  sram_wmask;
  logic [8:0]  sram_addr;
  logic [63:0] sram_din;
  logic [63:0] sram_dout;
  logic        init_done;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  sram22_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .WMASK_WIDTH(8)) r0 ();
  sram22_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .WMASK_WIDTH(8)) r1 ();

  sram22_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .WMASK_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (r0),
    .req1       (r1),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout),
    .init_done  (init_done)
  );

  // Behavioural macro; with the init feature the contents start as junk so the sweep must clear it.
  logic [63:0] mem [512];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) begin
`ifdef SRAM22_ARB_INIT_EN
        mem[i] <= 64'hDEAD_BEEF_0000_0000 | 64'(i);
`else
        mem[i] <= 64'h0;
`endif
      end
      mem_ready <= 1'b1;
    end else if (sram_we) begin
      for (int b = 0; b < 8; b++)
        if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
      sram_dout <= 'x;
    end else begin
      sram_dout <= mem[sram_addr];
    end
  end

  task automatic idle_inputs();
    r0.req_valid = 1'b0; r0.req_we = 1'b0; r0.req_wmask = 8'h00; r0.req_addr = 9'd0;
    r0.req_wdata = 64'h0; r0.rsp_ready = 1'b0;
    r1.req_valid = 1'b0; r1.req_we = 1'b0; r1.req_wmask = 8'h00; r1.req_addr = 9'd0;
    r1.req_wdata = 64'h0; r1.rsp_ready = 1'b0;
  endtask

  task automatic wr0(input logic [8:0] addr, input logic [63:0] data, input logic [7:0] mask);
    r0.req_valid = 1'b1; r0.req_we = 1'b1; r0.req_addr = addr;
    r0.req_wdata = data; r0.req_wmask = mask;
    @(negedge clk);
    r0.req_valid = 1'b0; r0.req_we = 1'b0; r0.req_wmask = 8'h00;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    idle_inputs();
    r0.req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    cmp_cnt++; if (r0.req_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_req0_ready got=%b want=0", r0.req_ready); end
    cmp_cnt++; if (r0.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp0_valid got=%b want=0", r0.rsp_valid); end
    cmp_cnt++; if (r1.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp1_valid got=%b want=0", r1.rsp_valid); end
    cmp_cnt++; if (sram_we !== 1'b0) begin err_cnt++; $display("FAIL rst_sram_we got=%b want=0", sram_we); end
    cmp_cnt++; if (sram_wmask !== 8'h00) begin err_cnt++; $display("FAIL rst_sram_wmask got=%h want=00", sram_wmask); end
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SRAM22_ARB_INIT_EN
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      #1;
      if (init_done !== 1'b0 || sram_we !== 1'b1 || sram_wmask !== 8'hFF ||
          sram_addr !== 9'(i) || r0.req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    r0.req_valid = 1'b0;
    #1;
    cmp_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL init_sweep bad_cycles=%0d want=0", bad); end
    cmp_cnt++; if (init_done !== 1'b1) begin err_cnt++; $display("FAIL init_done_after got=%b want=1", init_done); end
`else
    bad = 0;
    r0.req_valid = 1'b0;
    #1;
    cmp_cnt++; if (init_done !== 1'b1) begin err_cnt++; $display("FAIL init_done_release got=%b want=1 bad=%0d", init_done, bad); end
`endif
    @(negedge clk);
    r1.req_valid = 1'b1; r1.req_we = 1'b0; r1.req_addr = 9'd100;
    #1;
    cmp_cnt++; if (r1.req_ready !== 1'b1) begin err_cnt++; $display("FAIL zero_rd_accept got=%b want=1", r1.req_ready); end
    @(negedge clk);
    r1.req_valid = 1'b0;
    @(negedge clk);
    #1;
    cmp_cnt++; if (r1.rsp_valid !== 1'b1 || r1.rsp_rdata !== 64'h0) begin
      err_cnt++; $display("FAIL zero_rd_data got=%b/%h want=1/0", r1.rsp_valid, r1.rsp_rdata); end
    r1.rsp_ready = 1'b1;
    @(negedge clk);
    r1.rsp_ready = 1'b0;
  endtask

  task automatic test_write_read();
    r0.req_valid = 1'b1; r0.req_we = 1'b1; r0.req_addr = 9'd5;
    r0.req_wdata = 64'h1122_3344_5566_7788; r0.req_wmask = 8'hFF;
    #1;
    cmp_cnt++; if (r0.req_ready !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 9'd5) begin
      err_cnt++; $display("FAIL wr_drive got rdy=%b we=%b addr=%0d want 1/1/5", r0.req_ready, sram_we, sram_addr); end
    @(negedge clk);
    r0.req_valid = 1'b0; r0.req_we = 1'b0;
    r1.req_valid = 1'b1; r1.req_we = 1'b0; r1.req_addr = 9'd5;
    #1;
    cmp_cnt++; if (r1.req_ready !== 1'b1 || sram_we !== 1'b0) begin
      err_cnt++; $display("FAIL raw_rd_accept got rdy=%b we=%b want 1/0", r1.req_ready, sram_we); end
    @(negedge clk);
    r1.req_valid = 1'b0;
    #1;
    cmp_cnt++; if (r1.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL raw_early got=%b want=0", r1.rsp_valid); end
    @(negedge clk);
    #1;
    cmp_cnt++; if (r1.rsp_valid !== 1'b1 || r1.rsp_rdata !== 64'h1122_3344_5566_7788) begin
      err_cnt++; $display("FAIL raw_data got=%b/%h want=1/1122334455667788", r1.rsp_valid, r1.rsp_rdata); end
    cmp_cnt++; if (r0.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL wr_no_rsp got=%b want=0", r0.rsp_valid); end
    r1.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    cmp_cnt++; if (r1.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL raw_pop got=%b want=0", r1.rsp_valid); end
    r1.rsp_ready = 1'b0;
  endtask

  task automatic test_alternate();
    bit          eg0 [7] = '{1, 0, 1, 0, 0, 0, 0};
    bit          eg1 [7] = '{0, 1, 0, 1, 0, 0, 0};
    bit          ev0 [7] = '{0, 0, 1, 0, 1, 0, 0};
    bit          ev1 [7] = '{0, 0, 0, 1, 0, 1, 0};
    logic [63:0] ed0 [7] = '{64'h0, 64'h0, A0, 64'h0, A1, 64'h0, 64'h0};
    logic [63:0] ed1 [7] = '{64'h0, 64'h0, 64'h0, B0, 64'h0, B1, 64'h0};
    wr0(9'd10, A0, 8'hFF);
    wr0(9'd11, A1, 8'hFF);
    wr0(9'd20, B0, 8'hFF);
    wr0(9'd21, B1, 8'hFF);
    r0.rsp_ready = 1'b1; r1.rsp_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      r0.req_valid = (c < 4); r0.req_we = 1'b0; r0.req_addr = (c < 1) ? 9'd10 : 9'd11;
      r1.req_valid = (c < 4); r1.req_we = 1'b0; r1.req_addr = (c < 2) ? 9'd20 : 9'd21;
      #1;
      cmp_cnt++; if (r0.req_ready !== eg0[c] || r1.req_ready !== eg1[c]) begin
        err_cnt++; $display("FAIL rr_grant c=%0d got=%b%b want=%b%b", c, r0.req_ready, r1.req_ready, eg0[c], eg1[c]); end
      cmp_cnt++; if (r0.rsp_valid !== ev0[c] || (ev0[c] && r0.rsp_rdata !== ed0[c])) begin
        err_cnt++; $display("FAIL rr_rsp0 c=%0d got=%b/%h want=%b/%h", c, r0.rsp_valid, r0.rsp_rdata, ev0[c], ed0[c]); end
      cmp_cnt++; if (r1.rsp_valid !== ev1[c] || (ev1[c] && r1.rsp_rdata !== ed1[c])) begin
        err_cnt++; $display("FAIL rr_rsp1 c=%0d got=%b/%h want=%b/%h", c, r1.rsp_valid, r1.rsp_rdata, ev1[c], ed1[c]); end
      @(negedge clk);
    end
    r0.rsp_ready = 1'b0; r1.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n0p = 0;
    int n1p = 0;
    r0.rsp_ready = 1'b0; r1.rsp_ready = 1'b1;
    r0.req_valid = 1'b1; r0.req_we = 1'b0; r0.req_addr = 9'd10;
    #1;
    cmp_cnt++; if (r0.req_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_acc1 got=%b want=1", r0.req_ready); end
    @(negedge clk); #1;
    cmp_cnt++; if (r0.req_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_acc2 got=%b want=1", r0.req_ready); end
    @(negedge clk); #1;
    cmp_cnt++; if (r0.req_ready !== 1'b0 || r0.rsp_valid !== 1'b1) begin
      err_cnt++; $display("FAIL bp_block1 got rdy=%b vld=%b want 0/1", r0.req_ready, r0.rsp_valid); end
    @(negedge clk);
    r1.req_valid = 1'b1; r1.req_we = 1'b0; r1.req_addr = 9'd20;
    #1;
    cmp_cnt++; if (r0.req_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_block2 got=%b want=0", r0.req_ready); end
    cmp_cnt++; if (r1.req_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_req1_free got=%b want=1", r1.req_ready); end
    @(negedge clk);
    r1.req_valid = 1'b0;
    r0.rsp_ready = 1'b1;
    #1;
    cmp_cnt++; if (r0.req_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_unblock got=%b want=1", r0.req_ready); end
    for (int i = 0; i < 8; i++) begin
      if (r0.rsp_valid === 1'b1) begin
        n0p++;
        cmp_cnt++; if (r0.rsp_rdata !== A0) begin err_cnt++; $display("FAIL bp_data0 got=%h want=%h", r0.rsp_rdata, A0); end
      end
      if (r1.rsp_valid === 1'b1) begin
        n1p++;
        cmp_cnt++; if (r1.rsp_rdata !== B0) begin err_cnt++; $display("FAIL bp_data1 got=%h want=%h", r1.rsp_rdata, B0); end
      end
      @(negedge clk);
      if (i == 0) r0.req_valid = 1'b0;
      #1;
    end
    cmp_cnt++; if (n0p !== 3) begin err_cnt++; $display("FAIL bp_count0 got=%0d want=3", n0p); end
    cmp_cnt++; if (n1p !== 1) begin err_cnt++; $display("FAIL bp_count1 got=%0d want=1", n1p); end
    r0.rsp_ready = 1'b0; r1.rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wmask();
    r0.rsp_ready = 1'b1;
    wr0(9'd30, 64'h0, 8'hFF);
    wr0(9'd30, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
    for (int i = 0; i < 2; i++) begin
      #1;
      cmp_cnt++; if (r0.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL wm_no_rsp i=%0d got=%b want=0", i, r0.rsp_valid); end
      @(negedge clk);
    end
    r0.req_valid = 1'b1; r0.req_we = 1'b0; r0.req_addr = 9'd30;
    @(negedge clk);
    r0.req_valid = 1'b0;
    @(negedge clk);
    #1;
    cmp_cnt++; if (r0.rsp_valid !== 1'b1 || r0.rsp_rdata !== 64'h0000_0000_0000_00FF) begin
      err_cnt++; $display("FAIL wm_data got=%b/%h want=1/00000000000000ff", r0.rsp_valid, r0.rsp_rdata); end
    @(negedge clk);
    #1;
    cmp_cnt++; if (r0.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL wm_drain got=%b want=0", r0.rsp_valid); end
    r0.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    r0.rsp_ready = 1'b0;
    r0.req_valid = 1'b1; r0.req_we = 1'b0; r0.req_addr = 9'd10;
    repeat (2) @(negedge clk);
    r0.req_valid = 1'b0;
    #1;
    cmp_cnt++; if (r0.rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL rm_pre got=%b want=1", r0.rsp_valid); end
    rst_n = 1'b0;
    #1;
    cmp_cnt++; if (r0.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rm_clear got=%b want=0", r0.rsp_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      cmp_cnt++; if (r0.rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rm_after i=%0d got=%b want=0", i, r0.rsp_valid); end
    end
    while (init_done !== 1'b1 && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    cmp_cnt++; if (init_done !== 1'b1) begin err_cnt++; $display("FAIL rm_init_timeout got=%b want=1", init_done); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_backpressure();
    test_wmask();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
